fetch_queue: RTL

//  Parametrised instruction-fetch front end: replaces bare PC + IF/ID-reg fetch path of the RV32IM core.

---
 rtl/fetch_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, imem request FSM and {PC, inst} FIFO to decode.
// Optional zero-latency bypass of an empty queue: define FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic [XLEN-1:0]          IMEM_ADDR,
    output logic                     IMEM_REQ,
    input  logic [31:0]              IMEM_DATA,
    input  logic                     IMEM_BUSYWAIT,
    input  logic                     REDIRECT,
    input  logic [XLEN-1:0]          REDIRECT_PC,
    input  logic                     STALL,
    output logic [31:0]              INST_OUT,
    output logic [XLEN-1:0]          PC_OUT,
    output logic                     VALID_OUT,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     MISALIGN_ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_FULL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mis_q, mis_d;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic accept;
    logic byp;
    logic push;
    logic deq;
    logic empty;

    assign empty = (count_q == '0);

    // FULL state is held exactly while COUNT == DEPTH
    assign IMEM_REQ  = (state_q != S_FULL) & ~REDIRECT & RST;
    assign IMEM_ADDR = fpc_q;
    assign accept    = IMEM_REQ & ~IMEM_BUSYWAIT;

`ifdef FETCH_BYPASS_EN
    assign byp = accept & empty;
`else
    assign byp = 1'b0;
`endif

    assign deq  = ~empty & ~STALL;
    assign push = accept & ~(byp & ~STALL);

    assign VALID_OUT    = ~empty | byp;
    assign COUNT        = count_q;
    assign MISALIGN_ERR = mis_q;

    always_comb begin
        INST_OUT = NOP;
        PC_OUT   = '0;
        unique case (1'b1)
            ~empty: begin
                INST_OUT = inst_mem[head_q];
                PC_OUT   = pc_mem[head_q];
            end
            byp: begin
                INST_OUT = IMEM_DATA;
                PC_OUT   = fpc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mis_d   = 1'b0;
        if (REDIRECT) begin
            state_d = S_FETCH;
            fpc_d   = {REDIRECT_PC[XLEN-1:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            mis_d   = |REDIRECT_PC[1:0];
        end else begin
            if (push)
                tail_d = tail_q + 1'b1;
            if (deq)
                head_d = head_q + 1'b1;
            if (accept)
                fpc_d = fpc_q + XLEN'(4);
            unique case ({push, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            unique case (state_q)
                S_FETCH, S_WAIT: begin
                    if (IMEM_BUSYWAIT)
                        state_d = S_WAIT;
                    else if (count_d == CW'(DEPTH))
                        state_d = S_FULL;
                    else
                        state_d = S_FETCH;
                end
                S_FULL: begin
                    if (deq)
                        state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    // Storage needs no reset: entries are only read while counted
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[tail_q] <= IMEM_DATA;
            pc_mem[tail_q]   <= fpc_q;
        end
    end

endmodule
